// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp codes and phase encoding shared by the traffic controller
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10
    } phase_t;

endpackage

// File: rtl/traffic_ctrl_multi_if.sv
// rtl/traffic_ctrl_multi_if.sv - demand/emergency inputs and lamp outputs of the controller
interface traffic_ctrl_multi_if #(
    parameter int NUM_DIR = 4
);
    localparam int DIR_W = $clog2(NUM_DIR);

    logic                   actuated;
    logic [NUM_DIR-1:0]     veh_req;
    logic                   emerg_req;
    logic [DIR_W-1:0]       emerg_dir;
    logic [2*NUM_DIR-1:0]   lights;
    logic [DIR_W-1:0]       cur_dir;
    logic [1:0]             phase;
    logic                   emerg_active;

    // Upstream side: drives demand and pre-emption, observes lamps.
    modport master (
        output actuated, veh_req, emerg_req, emerg_dir,
        input  lights, cur_dir, phase, emerg_active
    );

    // Controller side.
    modport slave (
        input  actuated, veh_req, emerg_req, emerg_dir,
        output lights, cur_dir, phase, emerg_active
    );

endinterface

// File: rtl/rr_next_dir.sv
// rtl/rr_next_dir.sv - picks the approach that receives the next green
module rr_next_dir #(
    parameter  int NUM_DIR = 4,
    localparam int DIR_W   = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] veh_req,
    input  logic [DIR_W-1:0]   cur_dir,
    input  logic               actuated,
    output logic [DIR_W-1:0]   next_dir,
    output logic               found
);

    // Fixed mode always advances by one; actuated mode scans cur+1.. wrapping,
    // so the current owner is only re-granted when nobody else is waiting.
    always_comb begin
        logic [DIR_W-1:0] idx;
        idx      = '0;
        next_dir = cur_dir;
        found    = 1'b0;
        if (!actuated) begin
            next_dir = DIR_W'((int'(cur_dir) + 1) % NUM_DIR);
            found    = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_DIR; k++) begin
                idx = DIR_W'((int'(cur_dir) + k) % NUM_DIR);
                if (!found && veh_req[idx]) begin
                    next_dir = idx;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// rtl/traffic_ctrl_multi.sv - multi-approach traffic light FSM with actuation and pre-emption
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 4,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    traffic_ctrl_multi_if.slave bus
);

    localparam int DIR_W   = $clog2(NUM_DIR);
    localparam int MAX_GY  = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
    localparam int MAX_CYC = (MAX_GY > ALLRED_CYC) ? MAX_GY : ALLRED_CYC;
    localparam int CNT_W   = (MAX_CYC <= 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(ALLRED_CYC - 1);

    phase_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIR_W-1:0]     dir_q, dir_d;
    logic [2*NUM_DIR-1:0] lights_q, lights_d;
    logic                 emerg_active_q, emerg_active_d;
    logic [DIR_W-1:0]     rr_dir;
    logic                 rr_found;
    logic                 emerg_valid;
    logic                 emerg_here;
    logic [1:0]           lamp_code;

    // Out-of-range emergency directions are ignored entirely.
    assign emerg_valid = bus.emerg_req && (int'(bus.emerg_dir) < NUM_DIR);
    assign emerg_here  = emerg_valid && (bus.emerg_dir == dir_q);

    rr_next_dir #(
        .NUM_DIR (NUM_DIR)
    ) u_rr_next_dir (
        .veh_req  (bus.veh_req),
        .cur_dir  (dir_q),
        .actuated (bus.actuated),
        .next_dir (rr_dir),
        .found    (rr_found)
    );

    // Next state, phase counter and green owner.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            PH_ALLRED: begin
                // Counter stays at 0 while waiting for demand in actuated mode.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (emerg_valid) begin
                    state_d = PH_GREEN;
                    dir_d   = bus.emerg_dir;
                    cnt_d   = G_LOAD;
                end else if (rr_found) begin
                    state_d = PH_GREEN;
                    dir_d   = rr_dir;
                    cnt_d   = G_LOAD;
                end
            end
            PH_GREEN: begin
                // A foreign emergency truncates the green; our own freezes it.
                if (emerg_valid && !emerg_here) begin
                    state_d = PH_YELLOW;
                    cnt_d   = Y_LOAD;
                end else if (emerg_here) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = PH_YELLOW;
                    cnt_d   = Y_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PH_YELLOW: begin
                if (cnt_q == '0) begin
                    state_d = PH_ALLRED;
                    cnt_d   = R_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = PH_ALLRED;
                cnt_d   = R_LOAD;
            end
        endcase
    end

    // Lamp decode from next state so lamps switch on the same edge as the phase.
    always_comb begin
        lights_d  = '0;
        lamp_code = LIGHT_RED;
        if (state_d == PH_GREEN) begin
            lamp_code = LIGHT_GREEN;
        end else if (state_d == PH_YELLOW) begin
            lamp_code = LIGHT_YELLOW;
        end
        for (int i = 0; i < NUM_DIR; i++) begin
            if (DIR_W'(i) == dir_d) begin
                lights_d[2*i +: 2] = lamp_code;
            end
        end
        emerg_active_d = (state_d == PH_GREEN) && emerg_valid && (bus.emerg_dir == dir_d);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= PH_ALLRED;
            cnt_q          <= R_LOAD;
            dir_q          <= DIR_W'(NUM_DIR - 1);
            lights_q       <= '0;
            emerg_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            lights_q       <= lights_d;
            emerg_active_q <= emerg_active_d;
        end
    end

    assign bus.lights       = lights_q;
    assign bus.cur_dir      = dir_q;
    assign bus.phase        = state_q;
    assign bus.emerg_active = emerg_active_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// tb/tb_traffic_ctrl_multi.sv - scoreboard bench for traffic_ctrl_multi
module tb_traffic_ctrl_multi;
    import traffic_pkg::*;

    typedef struct packed {
        logic [15:0] lights;
        logic [1:0]  phase;
        logic [2:0]  cur;
        logic        emerg;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    exp_t q4[$];
    exp_t q2[$];
    exp_t q8[$];

    traffic_ctrl_multi_if #(.NUM_DIR(4)) bus4 ();
    traffic_ctrl_multi_if #(.NUM_DIR(2)) bus2 ();
    traffic_ctrl_multi_if #(.NUM_DIR(8)) bus8 ();

    traffic_ctrl_multi #(.NUM_DIR(4), .GREEN_CYC(5), .YELLOW_CYC(2), .ALLRED_CYC(1)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );
    traffic_ctrl_multi #(.NUM_DIR(2), .GREEN_CYC(5), .YELLOW_CYC(2), .ALLRED_CYC(1)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );
    traffic_ctrl_multi #(.NUM_DIR(8), .GREEN_CYC(5), .YELLOW_CYC(2), .ALLRED_CYC(1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    function automatic exp_t mk(int dir, logic [1:0] code, logic [1:0] ph, logic em);
        exp_t e;
        e = '0;
        e.lights[2*dir +: 2] = code;
        e.phase = ph;
        e.cur   = 3'(dir);
        e.emerg = em;
        return e;
    endfunction

    function automatic exp_t obs4();
        exp_t e;
        e.lights = {8'h00, bus4.lights};
        e.phase  = bus4.phase;
        e.cur    = {1'b0, bus4.cur_dir};
        e.emerg  = bus4.emerg_active;
        return e;
    endfunction

    function automatic exp_t obs2();
        exp_t e;
        e.lights = {12'h000, bus2.lights};
        e.phase  = bus2.phase;
        e.cur    = {2'b00, bus2.cur_dir};
        e.emerg  = bus2.emerg_active;
        return e;
    endfunction

    function automatic exp_t obs8();
        exp_t e;
        e.lights = bus8.lights;
        e.phase  = bus8.phase;
        e.cur    = bus8.cur_dir;
        e.emerg  = bus8.emerg_active;
        return e;
    endfunction

    task automatic push(int which, exp_t e, int n);
        for (int i = 0; i < n; i++) begin
            case (which)
                2:       q2.push_back(e);
                8:       q8.push_back(e);
                default: q4.push_back(e);
            endcase
        end
    endtask

    // One full green/yellow/all-red slot for approach d.
    task automatic push_slot(int which, int d);
        push(which, mk(d, LIGHT_GREEN, PH_GREEN, 1'b0), 5);
        push(which, mk(d, LIGHT_YELLOW, PH_YELLOW, 1'b0), 2);
        push(which, mk(d, LIGHT_RED, PH_ALLRED, 1'b0), 1);
    endtask

    task automatic do_reset(logic act, logic [3:0] vreq);
        @(negedge clk);
        rst_n          = 1'b0;
        bus4.actuated  = act;
        bus4.veh_req   = vreq;
        bus4.emerg_req = 1'b0;
        bus4.emerg_dir = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Compares the main instance against q4, one entry per cycle starting now.
    task automatic drain4(string name, logic one_hot);
        exp_t e;
        exp_t a;
        int   cyc;
        int   nr;
        cyc = 0;
        while (q4.size() > 0) begin
            e = q4.pop_front();
            a = obs4();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s cyc %0d got L=%h P=%0d C=%0d E=%0d want L=%h P=%0d C=%0d E=%0d",
                         name, cyc, a.lights, a.phase, a.cur, a.emerg, e.lights, e.phase, e.cur, e.emerg);
            end
            if (one_hot) begin
                nr = 0;
                for (int j = 0; j < 4; j++) if (bus4.lights[2*j +: 2] != LIGHT_RED) nr++;
                checks++;
                if (nr > 1) begin
                    errors++;
                    $display("FAIL %s_onehot cyc %0d got %0d non-red want <=1", name, cyc, nr);
                end
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (obs4() !== mk(3, LIGHT_RED, PH_ALLRED, 1'b0)) begin
            errors++;
            $display("FAIL reset4 got L=%h P=%0d C=%0d E=%0d want L=0 P=0 C=3 E=0",
                     bus4.lights, bus4.phase, bus4.cur_dir, bus4.emerg_active);
        end
        checks++;
        if (obs2() !== mk(1, LIGHT_RED, PH_ALLRED, 1'b0)) begin
            errors++;
            $display("FAIL reset2 got L=%h C=%0d want L=0 C=1", bus2.lights, bus2.cur_dir);
        end
        checks++;
        if (obs8() !== mk(7, LIGHT_RED, PH_ALLRED, 1'b0)) begin
            errors++;
            $display("FAIL reset8 got L=%h C=%0d want L=0 C=7", bus8.lights, bus8.cur_dir);
        end
    endtask

    task automatic test_fixed();
        do_reset(1'b0, 4'b0000);
        push(4, mk(3, LIGHT_RED, PH_ALLRED, 1'b0), 1);
        for (int d = 0; d < 4; d++) push_slot(4, d);
        push(4, mk(0, LIGHT_GREEN, PH_GREEN, 1'b0), 1);
        drain4("fixed", 1'b1);
    endtask

    task automatic test_reset_mid_yellow();
        do_reset(1'b0, 4'b0000);
        push(4, mk(3, LIGHT_RED, PH_ALLRED, 1'b0), 1);
        push(4, mk(0, LIGHT_GREEN, PH_GREEN, 1'b0), 5);
        push(4, mk(0, LIGHT_YELLOW, PH_YELLOW, 1'b0), 1);
        drain4("pre_reset", 1'b0);
        // Now in the second yellow cycle; pulse reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs4() !== mk(3, LIGHT_RED, PH_ALLRED, 1'b0)) begin
            errors++;
            $display("FAIL async_reset got L=%h P=%0d C=%0d E=%0d want L=0 P=0 C=3 E=0",
                     bus4.lights, bus4.phase, bus4.cur_dir, bus4.emerg_active);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(4, mk(3, LIGHT_RED, PH_ALLRED, 1'b0), 1);
        push_slot(4, 0);
        push(4, mk(1, LIGHT_GREEN, PH_GREEN, 1'b0), 1);
        drain4("restart", 1'b0);
    endtask

    task automatic test_actuated_single();
        do_reset(1'b1, 4'b0100);
        push(4, mk(3, LIGHT_RED, PH_ALLRED, 1'b0), 1);
        for (int r = 0; r < 3; r++) push_slot(4, 2);
        push(4, mk(2, LIGHT_GREEN, PH_GREEN, 1'b0), 1);
        drain4("act_single", 1'b0);
    endtask

    task automatic test_actuated_idle();
        do_reset(1'b1, 4'b0000);
        push(4, mk(3, LIGHT_RED, PH_ALLRED, 1'b0), 11);
        drain4("act_idle", 1'b0);
        bus4.veh_req = 4'b1000;
        push(4, mk(3, LIGHT_RED, PH_ALLRED, 1'b0), 1);
        push_slot(4, 3);
        push(4, mk(3, LIGHT_GREEN, PH_GREEN, 1'b0), 1);
        drain4("act_wake", 1'b0);
    endtask

    task automatic test_emergency();
        do_reset(1'b0, 4'b0000);
        push(4, mk(3, LIGHT_RED, PH_ALLRED, 1'b0), 1);
        push(4, mk(0, LIGHT_GREEN, PH_GREEN, 1'b0), 1);
        drain4("emerg_pre", 1'b0);
        // Second green cycle of approach 0: request approach 2.
        bus4.emerg_req = 1'b1;
        bus4.emerg_dir = 2'd2;
        push(4, mk(0, LIGHT_GREEN, PH_GREEN, 1'b0), 1);
        push(4, mk(0, LIGHT_YELLOW, PH_YELLOW, 1'b0), 2);
        push(4, mk(0, LIGHT_RED, PH_ALLRED, 1'b0), 1);
        push(4, mk(2, LIGHT_GREEN, PH_GREEN, 1'b1), 19);
        drain4("emerg_hold", 1'b0);
        // Release after the 20th held cycle; the full 5-cycle green remains.
        bus4.emerg_req = 1'b0;
        push(4, mk(2, LIGHT_GREEN, PH_GREEN, 1'b1), 1);
        push(4, mk(2, LIGHT_GREEN, PH_GREEN, 1'b0), 4);
        push(4, mk(2, LIGHT_YELLOW, PH_YELLOW, 1'b0), 2);
        push(4, mk(2, LIGHT_RED, PH_ALLRED, 1'b0), 1);
        push(4, mk(3, LIGHT_GREEN, PH_GREEN, 1'b0), 1);
        drain4("emerg_release", 1'b0);
    endtask

    task automatic test_sweep();
        exp_t e;
        exp_t a;
        int   cyc;
        do_reset(1'b0, 4'b0000);
        push(2, mk(1, LIGHT_RED, PH_ALLRED, 1'b0), 1);
        push(8, mk(7, LIGHT_RED, PH_ALLRED, 1'b0), 1);
        for (int k = 0; k < 8; k++) begin
            push_slot(2, k % 2);
            push_slot(8, k);
        end
        push(2, mk(0, LIGHT_GREEN, PH_GREEN, 1'b0), 1);
        push(8, mk(0, LIGHT_GREEN, PH_GREEN, 1'b0), 1);
        cyc = 0;
        while (q2.size() > 0 && q8.size() > 0) begin
            e = q2.pop_front();
            a = obs2();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL sweep2 cyc %0d got L=%h P=%0d C=%0d want L=%h P=%0d C=%0d",
                         cyc, a.lights, a.phase, a.cur, e.lights, e.phase, e.cur);
            end
            e = q8.pop_front();
            a = obs8();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL sweep8 cyc %0d got L=%h P=%0d C=%0d want L=%h P=%0d C=%0d",
                         cyc, a.lights, a.phase, a.cur, e.lights, e.phase, e.cur);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus4.actuated  = 1'b0;
        bus4.veh_req   = 4'b0000;
        bus4.emerg_req = 1'b0;
        bus4.emerg_dir = 2'd0;
        bus2.actuated  = 1'b0;
        bus2.veh_req   = 2'b00;
        bus2.emerg_req = 1'b0;
        bus2.emerg_dir = 1'b0;
        bus8.actuated  = 1'b0;
        bus8.veh_req   = 8'h00;
        bus8.emerg_req = 1'b0;
        bus8.emerg_dir = 3'd0;

        test_reset();
        test_fixed();
        test_reset_mid_yellow();
        test_actuated_single();
        test_actuated_idle();
        test_emergency();
        test_sweep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
